load_store_unit: RTL and testbench

//  Multi-cycle data-memory access stage upstream of the 4x8 register file.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_wait_timer.sv | 39 +++
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 tb/tb_load_store_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and default widths for the load/store unit.
//   lsu_state_t : FSM state encoding (IDLE, REQ, WAIT, WB)
//   LSU_*       : default parameter values used by load_store_unit
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } lsu_state_t;

  localparam int LSU_DATA_W   = 8;
  localparam int LSU_ADDR_W   = 8;
  localparam int LSU_REG_AW   = 2;
  localparam int LSU_MAX_WAIT = 15;

endpackage

// File: rtl/lsu_wait_timer.sv
// lsu_wait_timer: counts WAIT cycles without a memory ack and flags the
// terminal count, so the FSM can abort a stalled access.
// Ports:
//   i_clk    clock
//   i_reset  synchronous active-high reset
//   i_clear  clear the count (new access accepted)
//   i_inc    one more WAIT cycle passed without ack
//   o_tc     current WAIT cycle is the MAX_WAIT-th one
// Only instantiated when LSU_TIMEOUT_EN is defined.
module lsu_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_tc
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The count holds the number of completed WAIT cycles, so the
  // MAX_WAIT-th WAIT cycle sees MAX_WAIT-1. The FSM leaves WAIT on
  // that cycle, so the counter never wraps.
  assign o_tc = (r_cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access stage feeding the 4x8
// register file. Takes one load/store from decode, runs a req/ack handshake
// with data memory and writes load data back through the register-file port.
// Ports:
//   CLK, reset                   clock, synchronous active-high reset
//   start/isLoad/isStore         command valid and operation (sampled in IDLE)
//   addr/storeData/destReg       command operands
//   memReq/memWe/memAddr/memWData  memory request side (registered)
//   memRData/memAck              memory response side
//   busy                         access in flight (state decode only)
//   isWrite/writeReg/writeData   register-file write port
//   done/timeoutErr              completion / abort pulses
// Build option: define LSU_TIMEOUT_EN to abort accesses that wait MAX_WAIT
// cycles without an ack; otherwise WAIT holds until ack and timeoutErr is 0.
//
// state | meaning
// IDLE  | no access; accepts a command with exactly one op set
// REQ   | first request cycle, memReq high
// WAIT  | memReq held until memAck (or timeout)
// WB    | load data written to the register file, done pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W   = LSU_DATA_W,
  parameter int ADDR_W   = LSU_ADDR_W,
  parameter int REG_AW   = LSU_REG_AW,
  parameter int MAX_WAIT = LSU_MAX_WAIT
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              isLoad,
  input  logic              isStore,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] storeData,
  input  logic [REG_AW-1:0] destReg,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memAck,
  output logic              busy,
  output logic              isWrite,
  output logic [REG_AW-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              done,
  output logic              timeoutErr
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("load_store_unit: MAX_WAIT must be at least 1");
  end

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic              r_is_load;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [REG_AW-1:0] r_dest;
  logic [DATA_W-1:0] r_rdata;

  logic w_accept;
  logic w_in_req;
  logic w_ack;
  logic w_timeout;

  // Commands with both or neither op set are dropped silently.
  assign w_accept = (r_state == IDLE) && start && (isLoad ^ isStore);
  assign w_in_req = (r_state == REQ) || (r_state == WAIT);
  assign w_ack    = w_in_req && memAck;

`ifdef LSU_TIMEOUT_EN
  logic w_tc;
  logic r_timeout;

  lsu_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .i_clk  (CLK),
    .i_reset(reset),
    .i_clear(w_accept),
    .i_inc  ((r_state == WAIT) && !memAck),
    .o_tc   (w_tc)
  );

  // An ack in the terminal-count cycle wins over the abort.
  assign w_timeout = (r_state == WAIT) && !memAck && w_tc;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
    end
  end

  assign timeoutErr = r_timeout;
`else
  assign w_timeout  = 1'b0;
  assign timeoutErr = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = REQ;
        end
      end
      REQ, WAIT: begin
        if (memAck) begin
          w_next = r_is_load ? WB : IDLE;
        end else if (w_timeout) begin
          w_next = IDLE;
        end else begin
          w_next = WAIT;
        end
      end
      WB: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_is_load <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_dest    <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_accept) begin
        r_is_load <= isLoad;
        r_addr    <= addr;
        r_wdata   <= storeData;
        r_dest    <= destReg;
      end
      if (w_ack && r_is_load) begin
        r_rdata <= memRData;
      end
    end
  end

  assign memReq    = w_in_req;
  assign memWe     = w_in_req && !r_is_load;
  assign memAddr   = r_addr;
  assign memWData  = r_wdata;
  assign busy      = (r_state != IDLE);
  assign isWrite   = (r_state == WB);
  assign writeReg  = r_dest;
  assign writeData = r_rdata;

  // A store completes in its ack cycle; a load completes in WB. The reset
  // term keeps an ack that races a mid-access reset from signalling done.
  assign done = !reset && ((r_state == WB) || (w_ack && !r_is_load));

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int RW = 2;
  localparam int MW = 15;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic [RW-1:0] rg;
    logic [DW-1:0] data;
  } wr_exp_t;

  logic          CLK = 1'b0;
  logic          reset;
  logic          start;
  logic          isLoad;
  logic          isStore;
  logic [AW-1:0] addr;
  logic [DW-1:0] storeData;
  logic [RW-1:0] destReg;
  logic          memReq;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWData;
  logic [DW-1:0] memRData;
  logic          memAck;
  logic          busy;
  logic          isWrite;
  logic [RW-1:0] writeReg;
  logic [DW-1:0] writeData;
  logic          done;
  logic          timeoutErr;

  int total = 0;
  int bad   = 0;

  mem_exp_t mq[$];
  wr_exp_t  wq[$];
  bit       dq[$];

  mem_exp_t m_exp;
  wr_exp_t  w_exp;
  bit       d_exp;
  logic     prev_req = 1'b0;

  load_store_unit #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .REG_AW  (RW),
    .MAX_WAIT(MW)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .isLoad    (isLoad),
    .isStore   (isStore),
    .addr      (addr),
    .storeData (storeData),
    .destReg   (destReg),
    .memReq    (memReq),
    .memWe     (memWe),
    .memAddr   (memAddr),
    .memWData  (memWData),
    .memRData  (memRData),
    .memAck    (memAck),
    .busy      (busy),
    .isWrite   (isWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .done      (done),
    .timeoutErr(timeoutErr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: compares DUT outputs against queued expectations.
  always @(negedge CLK) begin
    if (memReq && !prev_req) begin
      if (mq.size() == 0) begin
        chk("unexpected_memreq", 32'(memAddr), 32'hFFFF_FFFF);
      end else begin
        m_exp = mq.pop_front();
        chk("mem_we", 32'(memWe), 32'(m_exp.we));
        chk("mem_addr", 32'(memAddr), 32'(m_exp.addr));
        chk("mem_wdata", 32'(memWData), 32'(m_exp.wdata));
      end
    end
    prev_req = memReq;

    if (isWrite) begin
      if (wq.size() == 0) begin
        chk("unexpected_iswrite", 32'(writeReg), 32'hFFFF_FFFF);
      end else begin
        w_exp = wq.pop_front();
        chk("wr_reg", 32'(writeReg), 32'(w_exp.rg));
        chk("wr_data", 32'(writeData), 32'(w_exp.data));
      end
    end

    if (done) begin
      if (dq.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'h0);
      end else begin
        d_exp = dq.pop_front();
        chk("done_with_iswrite", 32'(isWrite), 32'(d_exp));
      end
    end

`ifndef LSU_TIMEOUT_EN
    if (timeoutErr) chk("timeout_tied_low", 32'(timeoutErr), 32'h0);
`endif
  end

  task automatic issue(input logic ld, input logic st, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [RW-1:0] r);
    @(posedge CLK); #1;
    start = 1'b1; isLoad = ld; isStore = st; addr = a; storeData = d; destReg = r;
    @(posedge CLK); #1;
    start = 1'b0; isLoad = 1'b0; isStore = 1'b0; addr = '0; storeData = '0; destReg = '0;
  endtask

  task automatic ack(input int dly, input logic [DW-1:0] rd);
    repeat (dly) begin
      @(posedge CLK); #1;
    end
    memAck = 1'b1; memRData = rd;
    @(posedge CLK); #1;
    memAck = 1'b0; memRData = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; isLoad = 1'b0; isStore = 1'b0;
    addr = '0; storeData = '0; destReg = '0; memRData = '0; memAck = 1'b0;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;

    // reset state
    @(negedge CLK);
    chk("rst_memreq", 32'(memReq), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_memaddr", 32'(memAddr), 0);
    chk("rst_memwdata", 32'(memWData), 0);
    chk("rst_writereg", 32'(writeReg), 0);
    chk("rst_writedata", 32'(writeData), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_timeout", 32'(timeoutErr), 0);

    // 1: load 0x10 -> r2, ack after 3 cycles with 0xA5
    mq.push_back('{we: 1'b0, addr: 8'h10, wdata: 8'h00});
    wq.push_back('{rg: 2'd2, data: 8'hA5});
    dq.push_back(1'b1);
    issue(1'b1, 1'b0, 8'h10, 8'h00, 2'd2);
    @(negedge CLK);
    chk("t1_busy_in_req", 32'(busy), 1);
    ack(3, 8'hA5);
    @(negedge CLK);
    chk("t1_busy_in_wb", 32'(busy), 1);
    @(negedge CLK);
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_iswrite_after", 32'(isWrite), 0);

    // 2: store 0x3C -> 0x20, ack in REQ cycle
    mq.push_back('{we: 1'b1, addr: 8'h20, wdata: 8'h3C});
    dq.push_back(1'b0);
    issue(1'b0, 1'b1, 8'h20, 8'h3C, 2'd0);
    ack(0, 8'h00);
    @(negedge CLK);
    chk("t2_done_one_cycle", 32'(done), 0);
    chk("t2_busy_after", 32'(busy), 0);
    chk("t2_memreq_after", 32'(memReq), 0);

    // 3a: both op bits set -> ignored
    issue(1'b1, 1'b1, 8'h55, 8'h66, 2'd1);
    repeat (3) begin
      @(negedge CLK);
      chk("t3_both_memreq", 32'(memReq), 0);
      chk("t3_both_busy", 32'(busy), 0);
    end

    // 3b: start while busy with a store -> ignored
    mq.push_back('{we: 1'b1, addr: 8'h44, wdata: 8'h77});
    dq.push_back(1'b0);
    issue(1'b0, 1'b1, 8'h44, 8'h77, 2'd0);
    start = 1'b1; isLoad = 1'b1; addr = 8'h99; storeData = 8'h12; destReg = 2'd3;
    @(posedge CLK); #1;
    start = 1'b0; isLoad = 1'b0; addr = '0; storeData = '0; destReg = '0;
    @(negedge CLK);
    chk("t3_busy_addr_stable", 32'(memAddr), 32'h44);
    chk("t3_busy_we_stable", 32'(memWe), 1);
    ack(0, 8'h00);
    repeat (3) @(negedge CLK);
    chk("t3_idle_after", 32'(busy), 0);

    // 4: reset during WAIT of a load, ack arrives next cycle
    mq.push_back('{we: 1'b0, addr: 8'h50, wdata: 8'h00});
    issue(1'b1, 1'b0, 8'h50, 8'h00, 2'd1);
    @(posedge CLK); #1;
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0; memAck = 1'b1; memRData = 8'hEE;
    @(negedge CLK);
    chk("t4_memreq", 32'(memReq), 0);
    chk("t4_iswrite", 32'(isWrite), 0);
    chk("t4_done", 32'(done), 0);
    chk("t4_busy", 32'(busy), 0);
    @(posedge CLK); #1;
    memAck = 1'b0; memRData = '0;
    @(negedge CLK);
    chk("t4_busy_later", 32'(busy), 0);
    chk("t4_iswrite_later", 32'(isWrite), 0);

`ifdef LSU_TIMEOUT_EN
    // 5a: no ack -> abort after MW WAIT cycles
    mq.push_back('{we: 1'b0, addr: 8'h60, wdata: 8'h00});
    issue(1'b1, 1'b0, 8'h60, 8'h00, 2'd1);
    repeat (MW) @(posedge CLK);
    @(negedge CLK);
    chk("t5_last_wait_req", 32'(memReq), 1);
    chk("t5_last_wait_err", 32'(timeoutErr), 0);
    @(negedge CLK);
    chk("t5_timeout", 32'(timeoutErr), 1);
    chk("t5_memreq_drop", 32'(memReq), 0);
    chk("t5_busy_drop", 32'(busy), 0);
    @(negedge CLK);
    chk("t5_timeout_pulse", 32'(timeoutErr), 0);

    // 5b: ack in the last WAIT cycle -> normal completion
    mq.push_back('{we: 1'b0, addr: 8'h61, wdata: 8'h00});
    wq.push_back('{rg: 2'd1, data: 8'h5A});
    dq.push_back(1'b1);
    issue(1'b1, 1'b0, 8'h61, 8'h00, 2'd1);
    ack(MW, 8'h5A);
    @(negedge CLK);
    chk("t5b_no_timeout", 32'(timeoutErr), 0);
    @(negedge CLK);
    chk("t5b_no_timeout_later", 32'(timeoutErr), 0);
`endif

    // 6: back-to-back loads, second start the cycle busy falls
    mq.push_back('{we: 1'b0, addr: 8'h30, wdata: 8'h00});
    mq.push_back('{we: 1'b0, addr: 8'h31, wdata: 8'h00});
    wq.push_back('{rg: 2'd0, data: 8'h11});
    wq.push_back('{rg: 2'd3, data: 8'hC7});
    dq.push_back(1'b1);
    dq.push_back(1'b1);
    issue(1'b1, 1'b0, 8'h30, 8'h00, 2'd0);
    ack(1, 8'h11);
    issue(1'b1, 1'b0, 8'h31, 8'h00, 2'd3);
    ack(0, 8'hC7);
    repeat (4) @(negedge CLK);

    chk("end_memq_empty", 32'(mq.size()), 0);
    chk("end_wrq_empty", 32'(wq.size()), 0);
    chk("end_doneq_empty", 32'(dq.size()), 0);
    chk("end_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
